// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage controller.
// Holds the FSM state enum, the default ACK_TIMEOUT, the WB control bit positions
// and the MEM/WB register payload struct.
package mem_stage_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam int ACK_TIMEOUT_DEF = 16;
   localparam int WB_REG_WRITE = 1;
   localparam int WB_MEM_TO_REG = 0;
   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] read_data;
      logic [31:0] alu_result;
      logic [4:0]  mux_out;
   } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load and bubble control.
// Ports: clk, rst_n (sync, active-low), load (capture in_d), bubble (clear, wins over load),
// in_d (next payload), out_q (registered payload).
module mem_wb_reg
   import mem_stage_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    load,
   input  logic    bubble,
   input  mem_wb_t in_d,
   output mem_wb_t out_q
);
   mem_wb_t wb_d;
   always_comb wb_d = bubble ? '0 : load ? in_d : out_q;
   always_ff @(posedge clk)
      if (!rst_n) out_q <= '0;
      else out_q <= wb_d;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage controller driving a handshaked data memory and the MEM/WB register.
// Ports: clk, startin_n (sync active-low reset); MEM_* EX/MEM fields in; dmem_* memory handshake;
// stall (freezes upstream regs), pc_src/pc_branch_target (branch redirect), mem_err (sticky);
// WB_* MEM/WB register outputs. Optional macro MEM_ALIGN_CHECK_EN rejects unaligned accesses.
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        startin_n,
   input  logic [1:0]  MEM_wb,
   input  logic        MEM_branch,
   input  logic        MEM_mem_read,
   input  logic        MEM_mem_write,
   input  logic [31:0] MEM_branch_target,
   input  logic        MEM_zero,
   input  logic [31:0] MEM_alu_result,
   input  logic [31:0] MEM_reg_data2,
   input  logic [4:0]  MEM_mux_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        pc_src,
   output logic [31:0] pc_branch_target,
   output logic        mem_err,
   output logic [1:0]  WB_wb,
   output logic [31:0] WB_read_data,
   output logic [31:0] WB_alu_result,
   output logic [4:0]  WB_mux_out
);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic mem_err_q, mem_err_d;
   logic [31:0] rdata_q, rdata_d;
   logic access, illegal, misalign, stall_c, wb_load, wb_bubble, in_access;
   mem_wb_t wb_in, wb_out;
   assign illegal = MEM_mem_read & MEM_mem_write;
   assign access = MEM_mem_read ^ MEM_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = access & (MEM_alu_result[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      mem_err_d = mem_err_q;
      rdata_d = rdata_q;
      stall_c = 1'b0;
      wb_load = 1'b0;
      wb_bubble = 1'b0;
      case (state_q)
         IDLE:
            if (illegal || misalign) begin
               mem_err_d = 1'b1;
               wb_bubble = 1'b1;
            end else if (access) begin
               stall_c = 1'b1;
               wb_bubble = 1'b1;
               cnt_d = '0;
               state_d = ACCESS;
            end else wb_load = 1'b1;
         ACCESS: begin
            stall_c = 1'b1;
            wb_bubble = 1'b1;
            if (dmem_ack) begin
               rdata_d = MEM_mem_write ? 32'h0 : dmem_rdata;
               state_d = DONE;
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
               mem_err_d = 1'b1;
               rdata_d = 32'h0;
               state_d = DONE;
            end else cnt_d = cnt_q + 1'b1;
         end
         DONE: begin
            wb_load = 1'b1;
            cnt_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!startin_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         mem_err_q <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         mem_err_q <= mem_err_d;
         rdata_q <= rdata_d;
      end
   // Request and its qualifiers come only from the state register, never from dmem_ack.
   assign in_access = (state_q == ACCESS);
   assign dmem_req = in_access;
   assign dmem_we = in_access & MEM_mem_write;
   assign dmem_addr = in_access ? MEM_alu_result : 32'h0;
   assign dmem_wdata = in_access ? MEM_reg_data2 : 32'h0;
   assign stall = startin_n & stall_c;
   assign pc_src = startin_n & MEM_branch & MEM_zero & ~stall;
   assign pc_branch_target = MEM_branch_target;
   assign mem_err = mem_err_q;
   // Read data is only meaningful on the DONE load; plain ALU ops write back zero.
   assign wb_in = '{wb: MEM_wb,
                    read_data: (state_q == DONE) ? rdata_q : 32'h0,
                    alu_result: MEM_alu_result,
                    mux_out: MEM_mux_out};
   mem_wb_reg u_mem_wb_reg (
      .clk(clk),
      .rst_n(startin_n),
      .load(wb_load),
      .bubble(wb_bubble),
      .in_d(wb_in),
      .out_q(wb_out)
   );
   assign WB_wb = wb_out.wb;
   assign WB_read_data = wb_out.read_data;
   assign WB_alu_result = wb_out.alu_result;
   assign WB_mux_out = wb_out.mux_out;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;
   logic        clk = 1'b0;
   logic        startin_n;
   logic [1:0]  MEM_wb;
   logic        MEM_branch, MEM_mem_read, MEM_mem_write, MEM_zero;
   logic [31:0] MEM_branch_target, MEM_alu_result, MEM_reg_data2;
   logic [4:0]  MEM_mux_out;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        stall, pc_src, mem_err;
   logic [1:0]  WB_wb;
   logic [31:0] WB_read_data, WB_alu_result, pc_branch_target;
   logic [4:0]  WB_mux_out;
   int n_chk = 0;
   int n_fail = 0;
   int stalls, acc, bad;

   mem_stage_ctrl #(.ACK_TIMEOUT(16)) dut (
      .clk(clk), .startin_n(startin_n),
      .MEM_wb(MEM_wb), .MEM_branch(MEM_branch), .MEM_mem_read(MEM_mem_read),
      .MEM_mem_write(MEM_mem_write), .MEM_branch_target(MEM_branch_target),
      .MEM_zero(MEM_zero), .MEM_alu_result(MEM_alu_result), .MEM_reg_data2(MEM_reg_data2),
      .MEM_mux_out(MEM_mux_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .pc_src(pc_src), .pc_branch_target(pc_branch_target), .mem_err(mem_err),
      .WB_wb(WB_wb), .WB_read_data(WB_read_data), .WB_alu_result(WB_alu_result),
      .WB_mux_out(WB_mux_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic rd, input logic wr, input logic [1:0] wb,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] mux);
      MEM_mem_read = rd;
      MEM_mem_write = wr;
      MEM_wb = wb;
      MEM_alu_result = alu;
      MEM_reg_data2 = wd;
      MEM_mux_out = mux;
      MEM_branch = 1'b0;
      MEM_zero = 1'b0;
      MEM_branch_target = 32'h0;
   endtask

   // Drives one memory op from IDLE until the first non-stall cycle (DONE); ack is raised
   // on ACCESS cycle index ack_after (negative = never). Bounded at 40 cycles.
   task automatic run_mem(input int ack_after, input logic [31:0] rdata,
                          output int n_stall, output int n_acc, output int n_bad);
      n_stall = 0;
      n_acc = 0;
      n_bad = 0;
      dmem_rdata = rdata;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!stall) break;
         n_stall++;
         dmem_ack = 1'b0;
         if (dmem_req) begin
            n_acc++;
            if (dmem_we !== MEM_mem_write || dmem_addr !== MEM_alu_result ||
                dmem_wdata !== MEM_reg_data2 || WB_wb !== 2'b00) n_bad++;
            dmem_ack = (n_acc - 1 == ack_after);
         end
      end
      dmem_ack = 1'b0;
   endtask

   initial begin
      startin_n = 1'b0;
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
      set_op(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd1);
      MEM_branch = 1'b1;
      MEM_zero = 1'b1;
      @(negedge clk);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_pc_src", {31'h0, pc_src}, 32'h0);
      tick();
      tick();
      check("rst_req", {31'h0, dmem_req}, 32'h0);
      check("rst_err", {31'h0, mem_err}, 32'h0);
      check("rst_wb", {30'h0, WB_wb}, 32'h0);
      check("rst_alu", WB_alu_result, 32'h0);

      set_op(1'b0, 1'b0, 2'b10, 32'h1234, 32'h0, 5'd7);
      startin_n = 1'b1;
      @(negedge clk);
      check("alu_stall", {31'h0, stall}, 32'h0);
      tick();
      check("alu_wb", {30'h0, WB_wb}, 32'h2);
      check("alu_res", WB_alu_result, 32'h1234);
      check("alu_mux", {27'h0, WB_mux_out}, 32'd7);
      check("alu_rdata", WB_read_data, 32'h0);
      check("alu_stall2", {31'h0, stall}, 32'h0);

      set_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      MEM_branch = 1'b1;
      MEM_zero = 1'b1;
      MEM_branch_target = 32'h100;
      #1;
      check("beq_pc_src", {31'h0, pc_src}, 32'h1);
      check("beq_target", pc_branch_target, 32'h100);
      MEM_zero = 1'b0;
      #1;
      check("bne_pc_src", {31'h0, pc_src}, 32'h0);

      set_op(1'b0, 1'b0, 2'b10, 32'h8, 32'h0, 5'd2);
      dmem_ack = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      tick();
      dmem_ack = 1'b0;
      check("stray_ack_rdata", WB_read_data, 32'h0);
      check("stray_ack_req", {31'h0, dmem_req}, 32'h0);

      set_op(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd9);
      run_mem(0, 32'hDEAD_BEEF, stalls, acc, bad);
      check("lw_stalls", stalls, 32'd2);
      check("lw_acc", acc, 32'd1);
      check("lw_hold", bad, 32'd0);
      check("lw_wb_bubble", {30'h0, WB_wb}, 32'h0);
      tick();
      check("lw_wb", {30'h0, WB_wb}, 32'h3);
      check("lw_rdata", WB_read_data, 32'hDEAD_BEEF);
      check("lw_alu", WB_alu_result, 32'h40);
      check("lw_mux", {27'h0, WB_mux_out}, 32'd9);
      set_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      tick();
      check("lw_wb_once", {30'h0, WB_wb}, 32'h0);

      set_op(1'b0, 1'b1, 2'b00, 32'h80, 32'h55, 5'd0);
      run_mem(2, 32'hDEAD_BEEF, stalls, acc, bad);
      check("sw_stalls", stalls, 32'd4);
      check("sw_acc", acc, 32'd3);
      check("sw_hold", bad, 32'd0);
      tick();
      check("sw_wb", {30'h0, WB_wb}, 32'h0);
      check("sw_rdata", WB_read_data, 32'h0);
      check("sw_err", {31'h0, mem_err}, 32'h0);

      set_op(1'b1, 1'b0, 2'b11, 32'h44, 32'h0, 5'd4);
      run_mem(-1, 32'h1111_2222, stalls, acc, bad);
      check("to_stalls", stalls, 32'd17);
      check("to_acc", acc, 32'd16);
      tick();
      check("to_err", {31'h0, mem_err}, 32'h1);
      check("to_rdata", WB_read_data, 32'h0);
      check("to_wb", {30'h0, WB_wb}, 32'h3);
      set_op(1'b0, 1'b0, 2'b10, 32'h5, 32'h0, 5'd1);
      tick();
      check("err_sticky", {31'h0, mem_err}, 32'h1);

      startin_n = 1'b0;
      tick();
      startin_n = 1'b1;
      check("rst_clears_err", {31'h0, mem_err}, 32'h0);

      set_op(1'b1, 1'b1, 2'b11, 32'h40, 32'h0, 5'd3);
      #1;
      check("ill_stall", {31'h0, stall}, 32'h0);
      tick();
      check("ill_req", {31'h0, dmem_req}, 32'h0);
      check("ill_err", {31'h0, mem_err}, 32'h1);
      check("ill_wb", {30'h0, WB_wb}, 32'h0);
      startin_n = 1'b0;
      tick();
      startin_n = 1'b1;

      set_op(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd3);
      tick();
      @(negedge clk);
      check("mid_req", {31'h0, dmem_req}, 32'h1);
      startin_n = 1'b0;
      dmem_ack = 1'b1;
      dmem_rdata = 32'hAAAA_AAAA;
      #1;
      check("mid_rst_stall", {31'h0, stall}, 32'h0);
      tick();
      dmem_ack = 1'b0;
      set_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      #1;
      check("mid_rst_req", {31'h0, dmem_req}, 32'h0);
      check("mid_rst_we", {31'h0, dmem_we}, 32'h0);
      check("mid_rst_err", {31'h0, mem_err}, 32'h0);
      check("mid_rst_wb", {30'h0, WB_wb}, 32'h0);
      check("mid_rst_rdata", WB_read_data, 32'h0);
      check("mid_rst_pc_src", {31'h0, pc_src}, 32'h0);
      startin_n = 1'b1;
      tick();
      check("post_rst_req", {31'h0, dmem_req}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
      set_op(1'b1, 1'b0, 2'b11, 32'h42, 32'h0, 5'd6);
      #1;
      check("mis_stall", {31'h0, stall}, 32'h0);
      tick();
      check("mis_req", {31'h0, dmem_req}, 32'h0);
      check("mis_err", {31'h0, mem_err}, 32'h1);
      check("mis_wb", {30'h0, WB_wb}, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter: ACK_TIMEOUT, default 16, max cycles waited in ACCESS for dmem_ack.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: startin_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: MEM_wb in 2, MEM_branch in 1, MEM_mem_read in 1, MEM_mem_write in 1, MEM_branch_target in 32, MEM_zero in 1, MEM_alu_result in 32, MEM_reg_data2 in 32, MEM_mux_out in 5; these are EX/MEM stage fields.
REQ-005 SHALL have data-memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_rdata in 32, dmem_ack in 1.
REQ-006 SHALL have ports: stall out 1 (freeze PC/IF/ID/EX/MEM regs), pc_src out 1, pc_branch_target out 32, mem_err out 1 (sticky).
REQ-007 SHALL have MEM/WB ports: WB_wb out 2, WB_read_data out 32, WB_alu_result out 32, WB_mux_out out 5.

Function
REQ-008 SHALL implement FSM with states IDLE, ACCESS, DONE.
REQ-009 access = MEM_mem_read XOR MEM_mem_write; both high SHALL be illegal: no access, mem_err set, bubble loaded.
REQ-010 IDLE, no access: stall=0; WB regs load MEM_wb, MEM_alu_result, MEM_mux_out, WB_read_data=0 at that edge (zero stall cycles).
REQ-011 IDLE, access: stall=1 combinationally; next state ACCESS; WB loads bubble (WB_wb=0).
REQ-012 ACCESS: dmem_req=1, dmem_we=MEM_mem_write, dmem_addr=MEM_alu_result, dmem_wdata=MEM_reg_data2, all stable until ack; stall=1; WB loads bubble.
REQ-013 ACCESS with dmem_ack=1: capture dmem_rdata (0 for writes); next state DONE.
REQ-014 ACCESS SHALL count cycles; at ACK_TIMEOUT cycles without ack: set mem_err, capture 0, next state DONE.
REQ-015 DONE: stall=0, dmem_req=0; WB loads MEM_wb, captured data, MEM_alu_result, MEM_mux_out; next state IDLE unconditionally.
REQ-016 Latency: access acked in first ACCESS cycle SHALL stall exactly 2 cycles, WB valid after 3rd edge.
REQ-017 dmem_ack outside ACCESS SHALL be ignored.
REQ-018 pc_src SHALL equal MEM_branch AND MEM_zero AND NOT stall, combinational; pc_branch_target = MEM_branch_target.
REQ-019 mem_err SHALL remain set until reset.
REQ-020 dmem_req SHALL be driven from registered state only (no combinational path from dmem_ack).

Reset
REQ-021 startin_n=0 at an edge SHALL force state IDLE, counter 0, mem_err 0, all WB_* 0.
REQ-022 Reset mid-ACCESS SHALL drop dmem_req the following cycle; pending ack ignored.
REQ-023 During reset stall SHALL be 0, pc_src 0.

Configuration
REQ-024 Macro MEM_ALIGN_CHECK_EN defined: access with MEM_alu_result[1:0]!=0 SHALL issue no request, set mem_err, stall 0, load bubble.
REQ-025 MEM_ALIGN_CHECK_EN undefined: address passed unmodified, no alignment check logic.

Structure
REQ-026 Package mem_stage_pkg SHALL hold state enum, ACK_TIMEOUT default, WB bit positions (wb[1]=RegWrite, wb[0]=MemtoReg).
REQ-027 MEM/WB output register SHALL be sub-module mem_wb_reg (load, bubble, reset inputs).

Verification
REQ-028 ALU op, MEM_wb=2'b10, alu_result=0x1234 -> next edge WB_wb=2'b10, WB_alu_result=0x1234, stall never 1.
REQ-029 lw, addr 0x40, ack on first ACCESS cycle, rdata 0xDEADBEEF -> stall 2 cycles, WB_read_data=0xDEADBEEF, WB_wb=2'b11 once.
REQ-030 sw, addr 0x80, wdata 0x55, ack after 3 cycles -> dmem_we=1 held, stall 4 cycles, WB_wb=0.
REQ-031 lw, no ack, ACK_TIMEOUT=16 -> DONE after 16 ACCESS cycles, mem_err=1, WB_read_data=0.
REQ-032 beq with MEM_zero=1, target 0x100 -> pc_src=1, pc_branch_target=0x100 same cycle; reset asserted mid-ACCESS -> dmem_req=0 next cycle, all outputs 0.
REQ-033 With MEM_ALIGN_CHECK_EN, lw addr 0x42 -> dmem_req never 1, mem_err=1, stall 0.
